// File: rtl/addsub_pipe.sv
// Two-stage valid/ready SUB/ADD/ABSDIFF/ACC unit with optional signed saturation.
// All registers update on the falling clock edge; flags travel with each result.
module addsub_pipe #(
   parameter int               WIDTH    = 64,
   parameter bit               SAT      = 1'b0,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] in_A,
   input  logic [WIDTH-1:0] in_B,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             MSB,
   output logic             ovf,
   output logic             zero,
   output logic [WIDTH-1:0] acc
);

   typedef enum logic [1:0] {
      OP_SUB     = 2'd0,
      OP_ADD     = 2'd1,
      OP_ABSDIFF = 2'd2,
      OP_ACC     = 2'd3
   } op_e;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   op_e              s1_mode_q, s1_mode_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             msb_q, msb_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             advance;
   logic [WIDTH-1:0] acc_src;
   logic [WIDTH-1:0] op_x;
   logic [WIDTH-1:0] op_y;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic             borrow;
   logic             carry_msb;
   logic [WIDTH-1:0] raw;
   logic             ovf_c;
   logic             msb_c;
   logic [WIDTH-1:0] res_c;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   // Stage-2 arithmetic; a clear landing on the commit edge replaces the accumulator operand.
   always_comb begin
      acc_src   = acc_clr ? ACC_INIT : acc_q;
      op_x      = (s1_mode_q == OP_ACC) ? acc_src : s1_a_q;
      op_y      = (s1_mode_q == OP_ACC) ? s1_a_q  : s1_b_q;
      sum_add   = {1'b0, op_x} + {1'b0, op_y};
      sum_sub   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + ONE;
      borrow    = ~sum_sub[WIDTH];
      carry_msb = sum_add[WIDTH-1] ^ op_x[WIDTH-1] ^ op_y[WIDTH-1];
      raw       = sum_add[WIDTH-1:0];
      ovf_c     = 1'b0;
      msb_c     = borrow;
      case (s1_mode_q)
         OP_SUB: begin
            raw   = sum_sub[WIDTH-1:0];
            ovf_c = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (raw[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         OP_ADD: begin
            ovf_c = sum_add[WIDTH] ^ carry_msb;
         end
         OP_ABSDIFF: begin
            raw = borrow ? (s1_b_q - s1_a_q) : (s1_a_q - s1_b_q);
         end
         default: begin
            ovf_c = sum_add[WIDTH] ^ carry_msb;
            msb_c = 1'b0;
         end
      endcase
      // On overflow the true result has the sign of the first operand.
      res_c = (SAT && ovf_c) ? (op_x[WIDTH-1] ? SMIN : SMAX) : raw;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_mode_d   = s1_mode_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      msb_d       = msb_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      acc_d       = acc_q;
      if (advance) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d    = in_A;
            s1_b_d    = in_B;
            s1_mode_d = op_e'(mode);
         end
         out_valid_d = s1_valid_q;
         if (acc_clr) begin
            acc_d = ACC_INIT;
         end
         if (s1_valid_q) begin
            result_d = res_c;
            msb_d    = msb_c;
            ovf_d    = ovf_c;
            zero_d   = (res_c == '0);
            if (s1_mode_q == OP_ACC) begin
               acc_d = res_c;
            end
         end
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_mode_q   <= OP_SUB;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         msb_q       <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         acc_q       <= ACC_INIT;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_mode_q   <= s1_mode_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         msb_q       <= msb_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Result    = result_q;
   assign MSB       = msb_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a wrapping instance and a saturating instance share one
// stimulus stream and are checked against an integer-arithmetic reference model.
module tb_addsub_pipe;

   localparam int W    = 8;
   localparam int SMAX = (1 << (W - 1)) - 1;
   localparam int SMIN = -(1 << (W - 1));
   localparam logic [W-1:0] INIT_WRAP = 8'h05;
   localparam logic [W-1:0] INIT_SAT  = 8'h00;

   typedef struct packed {
      logic [W-1:0] res;
      logic         msb;
      logic         ovf;
      logic         zero;
      logic [W-1:0] acc;
   } exp_t;

   typedef struct packed {
      exp_t w;
      exp_t s;
   } pair_t;

   logic         clk = 1'b1;
   logic         rst;
   logic         in_valid;
   logic         acc_clr;
   logic         out_ready;
   logic [1:0]   mode;
   logic [W-1:0] in_A;
   logic [W-1:0] in_B;

   logic         w_in_ready, w_out_valid, w_msb, w_ovf, w_zero;
   logic [W-1:0] w_result, w_acc;
   logic         s_in_ready, s_out_valid, s_msb, s_ovf, s_zero;
   logic [W-1:0] s_result, s_acc;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] macc_w;
   logic [W-1:0] macc_s;
   pair_t sb[$];

   addsub_pipe #(.WIDTH(W), .SAT(1'b0), .ACC_INIT(INIT_WRAP)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .mode(mode),
      .in_A(in_A), .in_B(in_B), .acc_clr(acc_clr), .out_valid(w_out_valid),
      .out_ready(out_ready), .Result(w_result), .MSB(w_msb), .ovf(w_ovf),
      .zero(w_zero), .acc(w_acc)
   );

   addsub_pipe #(.WIDTH(W), .SAT(1'b1), .ACC_INIT(INIT_SAT)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .mode(mode),
      .in_A(in_A), .in_B(in_B), .acc_clr(acc_clr), .out_valid(s_out_valid),
      .out_ready(out_ready), .Result(s_result), .MSB(s_msb), .ovf(s_ovf),
      .zero(s_zero), .acc(s_acc)
   );

   always #5 clk = ~clk;

   // Reference: exact signed/unsigned integer result, then overflow, clamp and wrap.
   function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] acc_in,
                                  input bit sat);
      exp_t e;
      int sa, sb_i, sacc, ua, ub, t, r;
      logic [31:0] rv;
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      sacc = int'($signed(acc_in));
      ua   = int'(a);
      ub   = int'(b);
      e.msb = (md != 2'd3) && (ua < ub);
      case (md)
         2'd0:    t = sa - sb_i;
         2'd1:    t = sa + sb_i;
         2'd2:    t = (ua >= ub) ? ua - ub : ub - ua;
         default: t = sacc + sa;
      endcase
      e.ovf  = (md != 2'd2) && (t > SMAX || t < SMIN);
      r      = (sat && e.ovf) ? ((t > 0) ? SMAX : SMIN) : t;
      rv     = r;
      e.res  = rv[W-1:0];
      e.zero = (e.res == '0);
      e.acc  = (md == 2'd3) ? e.res : acc_in;
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      mode      = 2'd0;
      in_A      = '0;
      in_B      = '0;
      rst       = 1'b1;
      tick();
      rst    = 1'b0;
      macc_w = INIT_WRAP;
      macc_s = INIT_SAT;
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc} !== {1'b0, 8'h00, 3'b000, INIT_WRAP}) begin
         errors++;
         $display("[TB] FAIL reset_state_wrap: got %h expected %h",
                  {w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc}, {1'b0, 8'h00, 3'b000, INIT_WRAP});
      end
      checks++;
      if ({s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc} !== {1'b0, 8'h00, 3'b000, INIT_SAT}) begin
         errors++;
         $display("[TB] FAIL reset_state_sat: got %h expected %h",
                  {s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc}, {1'b0, 8'h00, 3'b000, INIT_SAT});
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({w_in_ready, s_in_ready} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b expected 11", {w_in_ready, s_in_ready});
      end
      macc_w = INIT_WRAP;
      macc_s = INIT_SAT;
   endtask

   task automatic test_directed();
      logic [1:0]   md [7];
      logic [W-1:0] va [7];
      logic [W-1:0] vb [7];
      logic [10:0]  ew [7];
      logic [10:0]  es [7];
      md = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
      va = '{8'h05, 8'h80, 8'h03, 8'h44, 8'h7F, 8'hFF, 8'h80};
      vb = '{8'h07, 8'h01, 8'hF0, 8'h44, 8'h01, 8'h01, 8'h80};
      ew = '{{8'hFE, 3'b100}, {8'h7F, 3'b010}, {8'hED, 3'b100}, {8'h00, 3'b001},
             {8'h80, 3'b010}, {8'h00, 3'b001}, {8'h00, 3'b011}};
      es = '{{8'hFE, 3'b100}, {8'h80, 3'b010}, {8'hED, 3'b100}, {8'h00, 3'b001},
             {8'h7F, 3'b010}, {8'h00, 3'b001}, {8'h80, 3'b010}};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         mode     = md[i];
         in_A     = va[i];
         in_B     = vb[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checks++;
         if ({w_out_valid, s_out_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL latency_early[%0d]: got out_valid %b expected 00", i, {w_out_valid, s_out_valid});
         end
         tick();
         checks++;
         if ({w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc} !== {1'b1, ew[i], INIT_WRAP}) begin
            errors++;
            $display("[TB] FAIL directed_wrap[%0d]: got %h expected %h", i,
                     {w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc}, {1'b1, ew[i], INIT_WRAP});
         end
         checks++;
         if ({s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc} !== {1'b1, es[i], INIT_SAT}) begin
            errors++;
            $display("[TB] FAIL directed_sat[%0d]: got %h expected %h", i,
                     {s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc}, {1'b1, es[i], INIT_SAT});
         end
      end
   endtask

   task automatic test_acc();
      logic [W-1:0] rw [4];
      logic [W-1:0] rs [4];
      logic         ow [4];
      logic         os [4];
      rw = '{8'h45, 8'h85, 8'hC5, 8'h05};
      ow = '{1'b0, 1'b1, 1'b0, 1'b0};
      rs = '{8'h40, 8'h7F, 8'h7F, 8'h7F};
      os = '{1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      mode = 2'd3;
      in_A = 8'h40;
      for (int i = 0; i < 5; i++) begin
         in_valid = (i < 4);
         in_B     = W'($urandom);
         tick();
         if (i >= 1) begin
            checks++;
            if ({w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc} !==
                {1'b1, rw[i-1], 1'b0, ow[i-1], 1'b0, rw[i-1]}) begin
               errors++;
               $display("[TB] FAIL acc_seq_wrap[%0d]: got %h expected %h", i - 1,
                        {w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc},
                        {1'b1, rw[i-1], 1'b0, ow[i-1], 1'b0, rw[i-1]});
            end
            checks++;
            if ({s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc} !==
                {1'b1, rs[i-1], 1'b0, os[i-1], 1'b0, rs[i-1]}) begin
               errors++;
               $display("[TB] FAIL acc_seq_sat[%0d]: got %h expected %h", i - 1,
                        {s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc},
                        {1'b1, rs[i-1], 1'b0, os[i-1], 1'b0, rs[i-1]});
            end
         end
      end
      // Clear coinciding with the commit of an ACC op.
      in_A     = 8'h02;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_clr  = 1'b1;
      tick();
      acc_clr = 1'b0;
      checks++;
      if ({w_out_valid, w_result, w_acc, s_out_valid, s_result, s_acc} !==
          {1'b1, 8'h07, 8'h07, 1'b1, 8'h02, 8'h02}) begin
         errors++;
         $display("[TB] FAIL acc_clr_commit: got %h expected %h",
                  {w_out_valid, w_result, w_acc, s_out_valid, s_result, s_acc},
                  {1'b1, 8'h07, 8'h07, 1'b1, 8'h02, 8'h02});
      end
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      checks++;
      if ({w_out_valid, w_acc, s_out_valid, s_acc} !== {1'b0, INIT_WRAP, 1'b0, INIT_SAT}) begin
         errors++;
         $display("[TB] FAIL acc_clr_idle: got %h expected %h",
                  {w_out_valid, w_acc, s_out_valid, s_acc}, {1'b0, INIT_WRAP, 1'b0, INIT_SAT});
      end
      // A clear while the output is stalled must be ignored.
      in_A     = 8'h03;
      in_valid = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      checks++;
      if ({w_out_valid, w_acc, s_out_valid, s_acc} !== {1'b1, 8'h08, 1'b1, 8'h03}) begin
         errors++;
         $display("[TB] FAIL acc_clr_stalled: got %h expected %h",
                  {w_out_valid, w_acc, s_out_valid, s_acc}, {1'b1, 8'h08, 1'b1, 8'h03});
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_stream(input int n, input bit pattern);
      int    sent;
      int    cyc;
      logic  exp_rdy;
      logic [3:0] pat;
      pair_t p;
      pat  = 4'b1001;
      sent = 0;
      cyc  = 0;
      do_reset();
      sb.delete();
      while ((sent < n || sb.size() > 0) && cyc < n * 20 + 50) begin
         in_valid  = (sent < n) && (pattern || ($urandom_range(0, 3) != 0));
         mode      = pattern ? 2'd1 : 2'($urandom_range(0, 3));
         in_A      = W'($urandom);
         in_B      = W'($urandom);
         out_ready = pattern ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
         #1;
         exp_rdy = !w_out_valid || out_ready;
         checks++;
         if ({w_in_ready, s_in_ready} !== {exp_rdy, exp_rdy}) begin
            errors++;
            $display("[TB] FAIL stream_in_ready cyc %0d: got %b expected %b", cyc,
                     {w_in_ready, s_in_ready}, {exp_rdy, exp_rdy});
         end
         if (w_out_valid || s_out_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL stream_extra_output cyc %0d: got out_valid %b expected 00", cyc,
                        {w_out_valid, s_out_valid});
            end else begin
               if ({w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc,
                    s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc} !==
                   {1'b1, sb[0].w, 1'b1, sb[0].s}) begin
                  errors++;
                  $display("[TB] FAIL stream_output cyc %0d: got %h expected %h", cyc,
                           {w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc,
                            s_out_valid, s_result, s_msb, s_ovf, s_zero, s_acc},
                           {1'b1, sb[0].w, 1'b1, sb[0].s});
               end
               if (out_ready) begin
                  void'(sb.pop_front());
               end
            end
         end
         if (in_valid && exp_rdy) begin
            p.w    = model(mode, in_A, in_B, macc_w, 1'b0);
            p.s    = model(mode, in_A, in_B, macc_s, 1'b1);
            macc_w = p.w.acc;
            macc_s = p.s.acc;
            sb.push_back(p);
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (sb.size() != 0 || sent != n) begin
         errors++;
         $display("[TB] FAIL stream_complete: got %0d sent %0d pending expected %0d sent 0 pending",
                  sent, sb.size(), n);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      mode      = 2'd3;
      in_A      = 8'h11;
      in_valid  = 1'b1;
      tick();
      in_A = 8'h22;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if ({w_out_valid, w_acc, s_out_valid, s_acc} !== {1'b1, 8'h16, 1'b1, 8'h11}) begin
         errors++;
         $display("[TB] FAIL pre_reset_fill: got %h expected %h",
                  {w_out_valid, w_acc, s_out_valid, s_acc}, {1'b1, 8'h16, 1'b1, 8'h11});
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({w_out_valid, w_result, w_acc, s_out_valid, s_result, s_acc} !==
          {1'b0, 8'h00, INIT_WRAP, 1'b0, 8'h00, INIT_SAT}) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h expected %h",
                  {w_out_valid, w_result, w_acc, s_out_valid, s_result, s_acc},
                  {1'b0, 8'h00, INIT_WRAP, 1'b0, 8'h00, INIT_SAT});
      end
      #2;
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({w_out_valid, s_out_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL post_reset_ghost: got %b expected 00", {w_out_valid, s_out_valid});
      end
      mode     = 2'd0;
      in_A     = 8'h09;
      in_B     = 8'h04;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({w_out_valid, s_out_valid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL post_reset_latency: got %b expected 00", {w_out_valid, s_out_valid});
      end
      tick();
      checks++;
      if ({w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc} !== {1'b1, 8'h05, 3'b000, INIT_WRAP}) begin
         errors++;
         $display("[TB] FAIL post_reset_result: got %h expected %h",
                  {w_out_valid, w_result, w_msb, w_ovf, w_zero, w_acc}, {1'b1, 8'h05, 3'b000, INIT_WRAP});
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      acc_clr   = 1'b0;
      out_ready = 1'b1;
      mode      = 2'd0;
      in_A      = '0;
      in_B      = '0;
      test_reset();
      test_directed();
      test_acc();
      test_stream(5, 1'b1);
      test_stream(300, 1'b0);
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
